dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache placed between the MEM stage's load/store port and a multi-cycle, line-wide main memory.
- Hits are served in the same cycle with no stall.
- Misses assert a stall to the pipeline while a finite-state machine (FSM) writes back the victim line if it is dirty, then refills the line.
- The pipeline freezes all stages while cpu_stall_o is high.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_array.sv | 57 +++++
 rtl/dcache_ctrl.sv | 135 +++++++++++++
 tb/tb_dcache_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, default geometry and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_e;

  localparam int DEF_LINES  = 32;
  localparam int DEF_WORDS  = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_OFF_W  = $clog2(DEF_WORDS);
  localparam int DEF_IDX_W  = $clog2(DEF_LINES);
  localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - DEF_OFF_W - 2;

  // Byte-address field extraction; callers cast the result down to the field width.
  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
    return (addr >> 2) & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return (addr >> (2 + off_w)) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return addr >> (2 + off_w + idx_w);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous word and line writes.
module dcache_array #(
  parameter int LINES = 32,
  parameter int WORDS = 8,
  parameter int TAG_W = 22,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WORDS),
  localparam int LINE_W = 32 * WORDS
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_word_we,
  input  logic [OFF_W-1:0]  i_word_off,
  input  logic [31:0]       i_word_data,
  input  logic              i_line_we,
  input  logic [LINE_W-1:0] i_line_data,
  input  logic [TAG_W-1:0]  i_line_tag,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_line
);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data contents are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_tag[i_idx]  <= i_line_tag;
      r_data[i_idx] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_idx][{i_word_off, 5'b0} +: 32] <= i_word_data;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic, miss FSM, memory handshake.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int IDX_W  = $clog2(LINES),
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2,
  localparam int LINE_W = 32 * WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_e             r_state;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_tag;

  logic [OFF_W-1:0]   w_off;
  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_arr_idx;
  logic               w_valid;
  logic               w_dirty;
  logic [TAG_W-1:0]   w_tag_rd;
  logic [LINE_W-1:0]  w_line;
  logic               w_hit;
  logic               w_word_we;
  logic               w_line_we;

  assign w_off = OFF_W'(addr_off(32'(cpu_addr_i), OFF_W));
  assign w_idx = IDX_W'(addr_idx(32'(cpu_addr_i), OFF_W, IDX_W));
  assign w_tag = TAG_W'(addr_tag(32'(cpu_addr_i), OFF_W, IDX_W));

  // The miss is latched so the FSM finishes the line even if the request drops mid-miss.
  assign w_arr_idx = (r_state == ST_IDLE) ? w_idx : r_idx;

  assign w_hit     = (r_state == ST_IDLE) && cpu_req_i && w_valid && (w_tag_rd == w_tag);
  assign w_word_we = w_hit && cpu_we_i;
  assign w_line_we = (r_state == ST_ALLOCATE) && r_mem_req && mem_ack_i;

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_array (
    .i_clk       (clk_i),
    .i_rst_n     (rst_i),
    .i_idx       (w_arr_idx),
    .i_word_we   (w_word_we),
    .i_word_off  (w_off),
    .i_word_data (cpu_wdata_i),
    .i_line_we   (w_line_we),
    .i_line_data (mem_rdata_i),
    .i_line_tag  (r_tag),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag_rd),
    .o_line      (w_line)
  );

  assign cpu_rdata_o = (w_hit && !cpu_we_i) ? w_line[{w_off, 5'b0} +: 32] : 32'd0;
  assign cpu_stall_o = (r_state != ST_IDLE) || (cpu_req_i && !w_hit);
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = w_line;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_idx      <= '0;
      r_tag      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_i && !w_hit) begin
            r_idx     <= w_idx;
            r_tag     <= w_tag;
            r_mem_req <= 1'b1;
            if (w_valid && w_dirty) begin
              r_state    <= ST_WRITEBACK;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {w_tag_rd, w_idx, {(OFF_W + 2){1'b0}}};
            end else begin
              r_state    <= ST_ALLOCATE;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_tag, w_idx, {(OFF_W + 2){1'b0}}};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            r_state    <= ST_ALLOCATE;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {r_tag, r_idx, {(OFF_W + 2){1'b0}}};
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl: inputs change on the falling edge, outputs sampled 1ns later.
module tb_dcache_ctrl;

  logic         clk;
  logic         rstN;
  logic         cpuReq;
  logic         cpuWe;
  logic [31:0]  cpuAddr;
  logic [31:0]  cpuWdata;
  logic [31:0]  cpuRdata;
  logic         cpuStall;
  logic         memReq;
  logic         memWe;
  logic [31:0]  memAddr;
  logic [255:0] memWdata;
  logic [255:0] memRdata;
  logic         memAck;

  int total;
  int bad;
  int stallCount;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rstN),
    .cpu_req_i   (cpuReq),
    .cpu_we_i    (cpuWe),
    .cpu_addr_i  (cpuAddr),
    .cpu_wdata_i (cpuWdata),
    .cpu_rdata_o (cpuRdata),
    .cpu_stall_o (cpuStall),
    .mem_req_o   (memReq),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata),
    .mem_ack_i   (memAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fill line whose word i holds base + i.
  function automatic logic [255:0] makeLine(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    #1;
    total++; if (cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %0h want 0", cpuStall); end
    total++; if (memReq !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %0h want 0", memReq); end
    total++; if (memWe !== 1'b0) begin bad++; $display("[TB] FAIL reset_we: got %0h want 0", memWe); end
    total++; if (cpuRdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", cpuRdata); end
    rstN = 1'b1;
  endtask

  task automatic test_cold_load;
    logic [255:0] line;
    stallCount = 0;
    @(negedge clk);
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h0000_0004;
    #1;
    if (cpuStall) stallCount++;
    total++; if (cpuStall !== 1'b1) begin bad++; $display("[TB] FAIL cold_stall: got %0h want 1", cpuStall); end
    total++; if (memReq !== 1'b0) begin bad++; $display("[TB] FAIL cold_req_early: got %0h want 0", memReq); end
    @(negedge clk); #1;
    if (cpuStall) stallCount++;
    total++; if (memReq !== 1'b1) begin bad++; $display("[TB] FAIL cold_req: got %0h want 1", memReq); end
    total++; if (memWe !== 1'b0) begin bad++; $display("[TB] FAIL cold_we: got %0h want 0", memWe); end
    total++; if (memAddr !== 32'h0000_0000) begin bad++; $display("[TB] FAIL cold_addr: got %h want 00000000", memAddr); end
    @(negedge clk); #1;
    if (cpuStall) stallCount++;
    @(negedge clk); #1;
    if (cpuStall) stallCount++;
    line = makeLine(32'h1000_0000);
    line[63:32] = 32'hDEAD_BEEF;
    memRdata = line; memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    if (cpuStall) stallCount++;
    total++; if (cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL cold_done_stall: got %0h want 0", cpuStall); end
    total++; if (cpuRdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL cold_rdata: got %h want deadbeef", cpuRdata); end
    total++; if (memReq !== 1'b0) begin bad++; $display("[TB] FAIL cold_req_drop: got %0h want 0", memReq); end
    total++; if (stallCount !== 4) begin bad++; $display("[TB] FAIL cold_latency: got %0d want 4", stallCount); end
  endtask

  task automatic test_hit;
    @(negedge clk);
    cpuAddr = 32'h0000_0008;
    #1;
    total++; if (cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL hit_stall: got %0h want 0", cpuStall); end
    total++; if (cpuRdata !== 32'h1000_0002) begin bad++; $display("[TB] FAIL hit_rdata: got %h want 10000002", cpuRdata); end
    @(negedge clk); #1;
    total++; if (memReq !== 1'b0) begin bad++; $display("[TB] FAIL hit_req: got %0h want 0", memReq); end
  endtask

  task automatic test_store_hit;
    @(negedge clk);
    cpuWe = 1'b1; cpuAddr = 32'h0000_0004; cpuWdata = 32'h1234_5678;
    #1;
    total++; if (cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL store_stall: got %0h want 0", cpuStall); end
    total++; if (cpuRdata !== 32'd0) begin bad++; $display("[TB] FAIL store_rdata_zero: got %h want 0", cpuRdata); end
    @(negedge clk);
    cpuWe = 1'b0;
    #1;
    total++; if (cpuRdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL store_readback: got %h want 12345678", cpuRdata); end
    total++; if (cpuStall !== 1'b0 || memReq !== 1'b0) begin bad++; $display("[TB] FAIL store_traffic: stall=%0h req=%0h want 0 0", cpuStall, memReq); end
  endtask

  task automatic test_conflict_miss;
    @(negedge clk);
    cpuAddr = 32'h0000_0404;
    #1;
    total++; if (cpuStall !== 1'b1) begin bad++; $display("[TB] FAIL conf_stall: got %0h want 1", cpuStall); end
    @(negedge clk); #1;
    total++; if (memReq !== 1'b1 || memWe !== 1'b1) begin bad++; $display("[TB] FAIL conf_wb_ctl: req=%0h we=%0h want 1 1", memReq, memWe); end
    total++; if (memAddr !== 32'h0000_0000) begin bad++; $display("[TB] FAIL conf_wb_addr: got %h want 00000000", memAddr); end
    total++; if (memWdata[63:32] !== 32'h1234_5678) begin bad++; $display("[TB] FAIL conf_wb_word1: got %h want 12345678", memWdata[63:32]); end
    total++; if (memWdata[95:64] !== 32'h1000_0002) begin bad++; $display("[TB] FAIL conf_wb_word2: got %h want 10000002", memWdata[95:64]); end
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (memReq !== 1'b1 || memWe !== 1'b0) begin bad++; $display("[TB] FAIL conf_fill_ctl: req=%0h we=%0h want 1 0", memReq, memWe); end
    total++; if (memAddr !== 32'h0000_0400) begin bad++; $display("[TB] FAIL conf_fill_addr: got %h want 00000400", memAddr); end
    total++; if (cpuStall !== 1'b1) begin bad++; $display("[TB] FAIL conf_fill_stall: got %0h want 1", cpuStall); end
    memRdata = makeLine(32'h2000_0000); memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL conf_done_stall: got %0h want 0", cpuStall); end
    total++; if (cpuRdata !== 32'h2000_0001) begin bad++; $display("[TB] FAIL conf_rdata: got %h want 20000001", cpuRdata); end
  endtask

  task automatic test_slow_memory;
    @(negedge clk);
    cpuAddr = 32'h0000_0808;
    #1;
    total++; if (cpuStall !== 1'b1) begin bad++; $display("[TB] FAIL slow_stall: got %0h want 1", cpuStall); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h0000_0800 || cpuStall !== 1'b1) begin
        bad++;
        $display("[TB] FAIL slow_hold%0d: req=%0h we=%0h addr=%h stall=%0h want 1 0 00000800 1", i, memReq, memWe, memAddr, cpuStall);
      end
    end
    memRdata = makeLine(32'h3000_0000); memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (cpuRdata !== 32'h3000_0002 || cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL slow_rdata: got %h stall=%0h want 30000002 0", cpuRdata, cpuStall); end
    cpuReq = 1'b0; memRdata = {8{32'hFFFF_FFFF}}; memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (memReq !== 1'b0 || cpuStall !== 1'b0) begin bad++; $display("[TB] FAIL stray_ack: req=%0h stall=%0h want 0 0", memReq, cpuStall); end
    total++; if (cpuRdata !== 32'd0) begin bad++; $display("[TB] FAIL idle_rdata: got %h want 0", cpuRdata); end
    cpuReq = 1'b1;
    #1;
    total++; if (cpuStall !== 1'b0 || cpuRdata !== 32'h3000_0002) begin bad++; $display("[TB] FAIL stray_line: got %h stall=%0h want 30000002 0", cpuRdata, cpuStall); end
  endtask

  task automatic test_store_miss;
    @(negedge clk);
    cpuWe = 1'b1; cpuAddr = 32'h0000_0C04; cpuWdata = 32'hCAFE_F00D;
    #1;
    total++; if (cpuStall !== 1'b1) begin bad++; $display("[TB] FAIL smiss_stall: got %0h want 1", cpuStall); end
    @(negedge clk); #1;
    total++; if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h0000_0C00) begin bad++; $display("[TB] FAIL smiss_fill: req=%0h we=%0h addr=%h want 1 0 00000c00", memReq, memWe, memAddr); end
    memRdata = makeLine(32'h4000_0000); memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (cpuStall !== 1'b0 || memReq !== 1'b0) begin bad++; $display("[TB] FAIL smiss_done: stall=%0h req=%0h want 0 0", cpuStall, memReq); end
    @(negedge clk);
    cpuWe = 1'b0;
    #1;
    total++; if (cpuRdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL smiss_word: got %h want cafef00d", cpuRdata); end
    cpuAddr = 32'h0000_0C08;
    #1;
    total++; if (cpuRdata !== 32'h4000_0002) begin bad++; $display("[TB] FAIL smiss_neighbor: got %h want 40000002", cpuRdata); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cpuAddr = 32'h0000_1004;
    #1;
    total++; if (cpuStall !== 1'b1) begin bad++; $display("[TB] FAIL rmid_stall: got %0h want 1", cpuStall); end
    @(negedge clk); #1;
    total++; if (memWe !== 1'b1 || memAddr !== 32'h0000_0C00 || memWdata[63:32] !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL rmid_wb: we=%0h addr=%h word1=%h want 1 00000c00 cafef00d", memWe, memAddr, memWdata[63:32]); end
    memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL rmid_alloc: req=%0h we=%0h addr=%h want 1 0 00001000", memReq, memWe, memAddr); end
    rstN = 1'b0;
    #1;
    total++; if (memReq !== 1'b0 || memWe !== 1'b0) begin bad++; $display("[TB] FAIL rmid_async: req=%0h we=%0h want 0 0", memReq, memWe); end
    @(negedge clk);
    rstN = 1'b1; cpuAddr = 32'h0000_0004;
    #1;
    total++; if (cpuStall !== 1'b1 || memReq !== 1'b0) begin bad++; $display("[TB] FAIL rmid_remiss: stall=%0h req=%0h want 1 0", cpuStall, memReq); end
    @(negedge clk); #1;
    total++; if (memReq !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h0000_0000) begin bad++; $display("[TB] FAIL rmid_refill: req=%0h we=%0h addr=%h want 1 0 00000000", memReq, memWe, memAddr); end
    memRdata = makeLine(32'h5000_0000); memAck = 1'b1;
    @(negedge clk);
    memAck = 1'b0;
    #1;
    total++; if (cpuStall !== 1'b0 || cpuRdata !== 32'h5000_0001) begin bad++; $display("[TB] FAIL rmid_done: got %h stall=%0h want 50000001 0", cpuRdata, cpuStall); end
    cpuReq = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; stallCount = 0;
    rstN = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    memRdata = '0; memAck = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_cold_load;
    test_hit;
    test_store_hit;
    test_conflict_miss;
    test_slow_memory;
    test_store_miss;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
